// File: rtl/slot_reel_controller.sv
// Slot-machine game sequencer: takes the bet, stops the three reels one at a time,
// captures and scores the final digits and keeps the player's credit balance.
module slot_reel_controller #(
    parameter int CREDIT_W      = 8,
    parameter int START_CREDITS = 10,
    parameter int BET           = 1,
    parameter int PAY_PAIR      = 2,
    parameter int PAY_TRIPLE    = 10,
    parameter int AUTO_STOP     = 255
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [3:0]          i_reel0,
    input  logic [3:0]          i_reel1,
    input  logic [3:0]          i_reel2,
    output logic [2:0]          o_pause,
    output logic [11:0]         o_digits,
    output logic [1:0]          o_win,
    output logic                o_result_valid,
    output logic [CREDIT_W-1:0] o_credits,
    output logic                o_busy,
    output logic                o_no_credit
);

    localparam int                  TMR_W    = (AUTO_STOP > 1) ? $clog2(AUTO_STOP) : 1;
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(AUTO_STOP - 1);
    localparam logic [CREDIT_W-1:0] BET_C    = CREDIT_W'(BET);
    localparam logic [CREDIT_W-1:0] START_C  = CREDIT_W'(START_CREDITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPIN   = 3'd1,
        SETTLE = 3'd2,
        EVAL   = 3'd3,
        PAYOUT = 3'd4
    } state_t;

    state_t           state;
    logic [1:0]       idx;
    logic [TMR_W-1:0] timer;
    logic             stop_q;
    logic             stop_evt;

    function automatic logic [1:0] classify(input logic [11:0] digits);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        d0 = digits[3:0];
        d1 = digits[7:4];
        d2 = digits[11:8];
        if (d0 == d1 && d1 == d2)
            return 2'b10;
        else if (d0 == d1 || d1 == d2 || d0 == d2)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // The balance clamps at all-ones instead of wrapping on a large win.
    function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] base,
                                                    input logic [1:0]          win);
        logic [CREDIT_W:0] pay;
        logic [CREDIT_W:0] sum;
        case (win)
            2'b10:   pay = (CREDIT_W+1)'(PAY_TRIPLE);
            2'b01:   pay = (CREDIT_W+1)'(PAY_PAIR);
            default: pay = '0;
        endcase
        sum = {1'b0, base} + pay;
        return sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
    endfunction

    // Registered rising-edge detect: a press costs one extra cycle but is glitch free.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            stop_q   <= 1'b0;
            stop_evt <= 1'b0;
        end else begin
            stop_q   <= i_stop;
            stop_evt <= i_stop & ~stop_q;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state          <= IDLE;
            o_pause        <= 3'b111;
            o_digits       <= '0;
            o_win          <= 2'b00;
            o_result_valid <= 1'b0;
            o_credits      <= START_C;
            idx            <= 2'd0;
            timer          <= '0;
        end else begin
            o_result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    o_pause <= 3'b111;
                    if (i_start && o_credits >= BET_C) begin
                        o_credits <= o_credits - BET_C;
                        o_win     <= 2'b00;
                        o_pause   <= 3'b000;
                        idx       <= 2'd0;
                        timer     <= '0;
                        state     <= SPIN;
                    end
                end
                SPIN: begin
                    if (stop_evt || timer == TMR_LAST) begin
                        o_pause[idx] <= 1'b1;
                        timer        <= '0;
                        state        <= SETTLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                // Stop edges seen here are dropped; the next reel needs a fresh press.
                SETTLE: begin
                    case (idx)
                        2'd0:    o_digits[3:0]  <= i_reel0;
                        2'd1:    o_digits[7:4]  <= i_reel1;
                        default: o_digits[11:8] <= i_reel2;
                    endcase
                    if (idx == 2'd2) begin
                        state <= EVAL;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= SPIN;
                    end
                end
                EVAL: begin
                    o_win <= classify(o_digits);
                    state <= PAYOUT;
                end
                PAYOUT: begin
                    o_credits      <= sat_add(o_credits, o_win);
                    o_result_valid <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy      = (state != IDLE);
    assign o_no_credit = (state == IDLE) && (o_credits < BET_C);

endmodule

// File: tb/tb_slot_reel_controller.sv
// Scoreboard bench for slot_reel_controller: expected game results are queued at
// start and popped when the result pulse appears; a 4-bit instance covers saturation.
module tb_slot_reel_controller;

    localparam int AUTO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] r0, r1, r2;

    logic [2:0]  a_pause, b_pause;
    logic [11:0] a_digits, b_digits;
    logic [1:0]  a_win, b_win;
    logic        a_rv, b_rv, a_busy, b_busy, a_nc, b_nc;
    logic [7:0]  a_credits;
    logic [3:0]  b_credits;

    typedef struct {
        logic [11:0] digits;
        logic [1:0]  win;
        logic [7:0]  credits;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   model_cr;

    always #5 clk = ~clk;

    slot_reel_controller #(.AUTO_STOP(AUTO)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_stop(stop),
        .i_reel0(r0), .i_reel1(r1), .i_reel2(r2),
        .o_pause(a_pause), .o_digits(a_digits), .o_win(a_win),
        .o_result_valid(a_rv), .o_credits(a_credits), .o_busy(a_busy),
        .o_no_credit(a_nc)
    );

    slot_reel_controller #(.CREDIT_W(4), .START_CREDITS(15), .AUTO_STOP(AUTO)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_stop(stop),
        .i_reel0(r0), .i_reel1(r1), .i_reel2(r2),
        .o_pause(b_pause), .o_digits(b_digits), .o_win(b_win),
        .o_result_valid(b_rv), .o_credits(b_credits), .o_busy(b_busy),
        .o_no_credit(b_nc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] win_of(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c);
        if (a == b && b == c) return 2'b10;
        if (a == b || b == c || a == c) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        if (a_rv === 1'b1) begin
            chk("result_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("digits", a_digits, e.digits);
                chk("win", a_win, e.win);
                chk("credits", a_credits, e.credits);
            end
        end
    end

    task automatic play_game(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input bit auto_mode);
        logic [1:0] w;
        int         pay;
        int         cnt;
        int         pre;
        r0  = d0;
        r1  = d1;
        r2  = d2;
        w   = win_of(d0, d1, d2);
        pay = (w == 2'b10) ? 10 : (w == 2'b01) ? 2 : 0;
        pre = model_cr;
        model_cr = model_cr - 1 + pay;
        if (model_cr > 255) model_cr = 255;
        sb.push_back('{digits: {d2, d1, d0}, win: w, credits: 8'(model_cr)});

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("pause_spin", a_pause, 3'b000);
        chk("busy_spin", a_busy, 1);
        chk("credits_bet", a_credits, 32'(pre - 1));
        chk("win_cleared", a_win, 2'b00);

        for (int k = 0; k < 3; k++) begin
            if (!auto_mode) begin
                repeat (2) @(negedge clk);
                stop = 1'b1;
                @(posedge clk); #1;
                chk("stop_lat_early", a_pause[k], 0);
                @(posedge clk); #1;
                chk("stop_lat_pause", a_pause, 32'((1 << (k + 1)) - 1));
                @(negedge clk) stop = 1'b0;
            end else begin
                cnt = 0;
                do begin
                    @(posedge clk); #1;
                    cnt++;
                end while (a_pause[k] !== 1'b1 && cnt < 3 * AUTO);
                chk("auto_gap", cnt, (k == 0) ? AUTO : AUTO + 1);
                chk("auto_pause", a_pause, 32'((1 << (k + 1)) - 1));
            end
        end
        if (!auto_mode) begin
            // back to the instant just after the third pause edge
            @(posedge clk); #1;
            cnt = 1;
        end else begin
            cnt = 0;
        end
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (a_rv !== 1'b1 && cnt < 10);
        chk("result_lat", cnt, 3);
        @(posedge clk); #1;
        chk("rv_one_cycle", a_rv, 0);
        chk("busy_idle", a_busy, 0);
        chk("win_held", a_win, w);
        chk("digits_held", a_digits, {d2, d1, d0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached expected finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        r0 = 4'd0; r1 = 4'd0; r2 = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pause", a_pause, 3'b111);
        chk("rst_credits", a_credits, 10);
        chk("rst_busy", a_busy, 0);
        chk("rst_win", a_win, 0);
        chk("rst_rv", a_rv, 0);
        chk("rst_digits", a_digits, 0);
        chk("rst_no_credit", a_nc, 0);
        @(negedge clk) rst = 1'b0;
        model_cr = 10;

        play_game(4'd7, 4'd7, 4'd7, 1'b0);
        chk("sat_credits_b", b_credits, 15);
        chk("sat_win_b", b_win, 2'b10);
        play_game(4'd3, 4'd3, 4'd5, 1'b0);
        play_game(4'd1, 4'd2, 4'd3, 1'b0);
        play_game(4'd9, 4'd0, 4'd9, 1'b0);
        play_game(4'd8, 4'd6, 4'd4, 1'b1);

        // Held start and held stop in SPIN, then reset mid-game.
        r0 = 4'd5; r1 = 4'd5; r2 = 4'd5;
        @(negedge clk) start = 1'b1;
        @(negedge clk) stop = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_stop_pause", a_pause, 3'b001);
        chk("held_start_credits", a_credits, 32'(model_cr - 1));
        chk("held_busy", a_busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_pause", a_pause, 3'b111);
        chk("midrst_credits", a_credits, 10);
        chk("midrst_busy", a_busy, 0);
        @(posedge clk); #1;
        chk("midrst_idle", a_busy, 0);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk) rst = 1'b0;
        model_cr = 10;

        for (int g = 0; g < 10; g++) play_game(4'd1, 4'd2, 4'd3, 1'b0);
        chk("drained_credits", a_credits, 0);
        chk("no_credit", a_nc, 1);
        @(negedge clk) start = 1'b1;
        repeat (5) @(negedge clk);
        chk("nocredit_busy", a_busy, 0);
        chk("nocredit_credits", a_credits, 0);
        chk("nocredit_pause", a_pause, 3'b111);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
